// File: rtl/inst_fetch_reg.sv
// inst_fetch_reg: MOC-handshake instruction fetch feeding a 1-deep IR (2-deep when IR_PREFETCH_EN is defined).
module inst_fetch_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_din,
  input  logic              moc,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              ir_take,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target
);
`ifdef IR_PREFETCH_EN
  localparam logic [1:0] D = 2'd2;
`else
  localparam logic [1:0] D = 2'd1;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t r_state, w_state_nx;
  logic [1:0] r_cnt, w_base, w_cnt_nx;
  logic [ADDR_W-1:0] r_fetch_pc, r_pend_pc, w_fetch_nx, w_tgt, r_pc0, w_pc0_nx;
  logic [31:0] r_ir0, w_ir0_nx;
  logic w_take, w_wr, w_orphan;
  assign w_tgt    = pc_target & ~ADDR_W'(3);
  assign w_take   = ir_take & (r_cnt != 2'd0);
  assign w_wr     = (r_state == WAIT) & moc & ~pc_load;
  assign w_orphan = pc_load & (r_state != IDLE) & ~moc;
  assign w_base   = r_cnt - {1'b0, w_take};
  assign w_cnt_nx = pc_load ? 2'd0 : w_base + {1'b0, w_wr};
  always_comb begin
    w_state_nx = (r_state == IDLE) ? ((!pc_load && w_base < D) ? WAIT : IDLE)
               : moc ? ((r_state == WAIT && !pc_load && w_cnt_nx < D) ? WAIT : IDLE)
               : pc_load ? DISCARD : r_state;
    // An orphaned request keeps its address on the bus; the target is parked until it completes.
    w_fetch_nx = w_orphan ? r_fetch_pc
               : pc_load ? w_tgt
               : (r_state == DISCARD && moc) ? r_pend_pc
               : w_wr ? r_fetch_pc + ADDR_W'(4) : r_fetch_pc;
  end
`ifdef IR_PREFETCH_EN
  logic [31:0] r_ir1;
  logic [ADDR_W-1:0] r_pc1;
  logic w_shift;
  assign w_shift  = w_take & (r_cnt == 2'd2);
  assign w_ir0_nx = (w_wr && w_base == 2'd0) ? mem_din : w_shift ? r_ir1 : r_ir0;
  assign w_pc0_nx = (w_wr && w_base == 2'd0) ? r_fetch_pc : w_shift ? r_pc1 : r_pc0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ir1 <= '0;
      r_pc1 <= RESET_PC;
    end else if (w_wr && w_base == 2'd1) begin
      r_ir1 <= mem_din;
      r_pc1 <= r_fetch_pc;
    end
`else
  assign w_ir0_nx = w_wr ? mem_din : r_ir0;
  assign w_pc0_nx = w_wr ? r_fetch_pc : r_pc0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
      r_ir0      <= '0;
      r_pc0      <= RESET_PC;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_fetch_pc <= w_fetch_nx;
      r_pend_pc  <= w_orphan ? w_tgt : r_pend_pc;
      r_ir0      <= w_ir0_nx;
      r_pc0      <= w_pc0_nx;
    end
  assign mem_rd   = r_state != IDLE;
  assign mem_addr = r_fetch_pc;
  assign ir_out   = r_ir0;
  assign pc_out   = r_pc0;
  assign ir_valid = r_cnt != 2'd0;
endmodule
